// File: rtl/acom_if.sv
// Requester-side access bus plus the byte-wide COM transmitter/receiver strobes of ACOM.
interface acom_if;
  logic        SlvReq;
  logic        SlvWrite;
  logic [31:0] SlvAddr;
  logic [31:0] SlvWData;
  logic [31:0] SlvRData;
  logic        SlvOkay;
  logic        SlvErr;
  logic        Busy;
  logic        Write;
  logic [7:0]  DataOut;
  logic        THEmpty;
  logic        Read;
  logic [7:0]  DataIn;
  logic        DataReady;

  modport slave (
    input  SlvReq, SlvWrite, SlvAddr, SlvWData, THEmpty, DataIn, DataReady,
    output SlvRData, SlvOkay, SlvErr, Busy, Write, DataOut, Read
  );

  modport master (
    output SlvReq, SlvWrite, SlvAddr, SlvWData, THEmpty, DataIn, DataReady,
    input  SlvRData, SlvOkay, SlvErr, Busy, Write, DataOut, Read
  );
endinterface

// File: rtl/acom.sv
// ACOM: turns one word access into a command/address/data byte stream on a COM link,
// collecting read data bytes back with an idle timeout.
//
// state     | meaning
// IDLE      | waiting for SlvReq, request fields latched on acceptance
// SEND_CMD  | sending command byte {1, write, 6'd1}
// SEND_ADDR | sending ADDR_SIZE address bytes, MSB first
// SEND_DATA | sending DATA_SIZE write data bytes, MSB first
// RECV_DATA | collecting DATA_SIZE read bytes, idle timeout armed
// DONE      | one-cycle SlvOkay or SlvErr
module acom #(
  parameter int          ADDR_SIZE = 4,
  parameter int          DATA_SIZE = 4,
  parameter logic [15:0] TIMEOUT   = 16'd4095
) (
  input logic   CLK,
  input logic   RST_N,
  acom_if.slave bus
);

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    SEND_CMD  = 6'b000010,
    SEND_ADDR = 6'b000100,
    SEND_DATA = 6'b001000,
    RECV_DATA = 6'b010000,
    DONE      = 6'b100000
  } state_t;

  localparam logic [7:0]  ADDR_LAST = 8'(ADDR_SIZE - 1);
  localparam logic [7:0]  DATA_LAST = 8'(DATA_SIZE - 1);
  localparam logic [15:0] TO_LAST   = TIMEOUT - 16'd1;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rx_q, rx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rx_d         = rx_q;
    cnt_d        = cnt_q;
    to_cnt_d     = to_cnt_q;
    bus.Write    = 1'b0;
    bus.DataOut  = 8'h00;
    bus.Read     = 1'b0;
    bus.SlvOkay  = 1'b0;
    bus.SlvErr   = 1'b0;
    bus.SlvRData = '0;
    bus.Busy     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.SlvReq) begin
          write_d  = bus.SlvWrite;
          addr_d   = bus.SlvAddr;
          wdata_d  = bus.SlvWData;
          err_d    = 1'b0;
          rx_d     = '0;
          cnt_d    = '0;
          to_cnt_d = '0;
          state_d  = SEND_CMD;
        end
      end
      SEND_CMD: begin
        bus.Write   = bus.THEmpty;
        bus.DataOut = {1'b1, write_q, 6'd1};
        if (bus.THEmpty) state_d = SEND_ADDR;
      end
      // address and data are shifted out of their top byte, so a stall simply holds them
      SEND_ADDR: begin
        bus.Write   = bus.THEmpty;
        bus.DataOut = addr_q[31:24];
        if (bus.THEmpty) begin
          addr_d = addr_q << 8;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = write_q ? SEND_DATA : RECV_DATA;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      SEND_DATA: begin
        bus.Write   = bus.THEmpty;
        bus.DataOut = wdata_q[31:24];
        if (bus.THEmpty) begin
          wdata_d = wdata_q << 8;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      // an arriving byte takes priority over the timeout in the same cycle
      RECV_DATA: begin
        bus.Read = bus.DataReady;
        if (bus.DataReady) begin
          rx_d     = {rx_q[23:0], bus.DataIn};
          to_cnt_d = '0;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      DONE: begin
        bus.SlvOkay  = ~err_q;
        bus.SlvErr   = err_q;
        bus.SlvRData = (write_q || err_q) ? 32'h0 : rx_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acom.sv
// Self-checking bench for acom: per-transaction byte-stream/timeout model driven by
// random and directed stimulus, compared cycle by cycle.
module tb_acom;
  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  acom_if bus ();

  acom #(.ADDR_SIZE(4), .DATA_SIZE(4), .TIMEOUT(16'(TO))) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},  32'(bus.Busy),    32'h0);
    check_val({tag, "_write"}, 32'(bus.Write),   32'h0);
    check_val({tag, "_dout"},  32'(bus.DataOut), 32'h0);
    check_val({tag, "_read"},  32'(bus.Read),    32'h0);
    check_val({tag, "_okay"},  32'(bus.SlvOkay), 32'h0);
    check_val({tag, "_err"},   32'(bus.SlvErr),  32'h0);
    check_val({tag, "_rdata"}, bus.SlvRData,     32'h0);
  endtask

  // te_mode: 0 THEmpty always 1, 1 random, 2 low for 3 cycles on the 2nd address byte.
  // gap < 0: random DataReady; otherwise DataReady after `gap` idle cycles per byte.
  // abort_at >= 0: pulse reset when that many bytes have been sent.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int supply, input int gap, input int te_mode, input int abort_at,
                         output int done_cyc, output bit err_o);
    logic [7:0]  exp_q[$];
    logic [31:0] rx;
    int          sent, rcv, idle, stall, phase;
    bit          err, te, dr, finished;
    logic [7:0]  din;
    exp_q.push_back({1'b1, wr, 6'd1});
    for (int i = 0; i < 4; i++) exp_q.push_back(addr[31-8*i -: 8]);
    if (wr) for (int i = 0; i < 4; i++) exp_q.push_back(wdata[31-8*i -: 8]);
    rx = '0; sent = 0; rcv = 0; idle = 0; stall = 3; err = 0; finished = 0;
    done_cyc = -1; err_o = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) phase = 0;
      else if (sent < exp_q.size()) phase = 1;
      else if (!wr && rcv < 4 && !err) phase = 2;
      else phase = 3;

      bus.SlvReq = 1'b1;
      if (cyc == 0) begin
        bus.SlvWrite = wr; bus.SlvAddr = addr; bus.SlvWData = wdata;
      end else begin
        bus.SlvWrite = 1'($urandom); bus.SlvAddr = $urandom; bus.SlvWData = $urandom;
      end
      if (te_mode == 0) te = 1'b1;
      else if (te_mode == 1) te = ($urandom_range(0, 3) != 0);
      else begin
        te = 1'b1;
        if (phase == 1 && sent == 2 && stall > 0) begin te = 1'b0; stall--; end
      end
      bus.THEmpty = te;
      if (phase == 2) begin
        if (rcv >= supply) dr = 1'b0;
        else if (gap < 0) dr = 1'($urandom_range(0, 1));
        else dr = (idle >= gap);
      end else begin
        dr = 1'($urandom_range(0, 1));
      end
      din = 8'($urandom);
      bus.DataReady = dr;
      bus.DataIn    = din;

      if (abort_at >= 0 && phase == 1 && sent == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        check_all_zero("abort_hold");
        rst_n = 1'b1;
        bus.SlvReq = 1'b0;
        return;
      end

      @(negedge clk);
      check_val("busy",  32'(bus.Busy),    32'(phase != 0));
      check_val("write", 32'(bus.Write),   (phase == 1) ? 32'(te) : 32'h0);
      check_val("dout",  32'(bus.DataOut), (phase == 1) ? 32'(exp_q[sent]) : 32'h0);
      check_val("read",  32'(bus.Read),    (phase == 2) ? 32'(dr) : 32'h0);
      check_val("okay",  32'(bus.SlvOkay), 32'(phase == 3 && !err));
      check_val("err",   32'(bus.SlvErr),  32'(phase == 3 && err));
      if (phase == 3) check_val("rdata", bus.SlvRData, (wr || err) ? 32'h0 : rx);

      case (phase)
        1: if (te) sent++;
        2: begin
          if (dr) begin
            rx = {rx[23:0], din}; rcv++; idle = 0;
          end else if (idle == TO - 1) begin
            err = 1'b1;
          end else begin
            idle++;
          end
        end
        3: begin
          done_cyc = cyc; err_o = err; finished = 1'b1;
        end
        default: ;
      endcase
    end
    if (!finished) check_val("txn_budget", 32'h0, 32'h1);
    bus.SlvReq = 1'b0;
    @(posedge clk); #1;
    bus.THEmpty = 1'b1;
    @(negedge clk);
    check_val("after_busy", 32'(bus.Busy),    32'h0);
    check_val("after_okay", 32'(bus.SlvOkay), 32'h0);
    check_val("after_wr",   32'(bus.Write),   32'h0);
  endtask

  initial begin
    int dc;
    bit e;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.SlvReq = 1'b1; bus.SlvWrite = 1'b1; bus.SlvAddr = '1; bus.SlvWData = '1;
    bus.THEmpty = 1'b1; bus.DataIn = 8'hFF; bus.DataReady = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    bus.SlvReq = 1'b0;

    run_txn(1'b1, 32'h12345678, 32'hCAFEF00D, 4, 0, 0, -1, dc, e);
    check_val("wr_latency", 32'(dc), 32'd10);

    run_txn(1'b0, 32'h00000010, 32'h0, 4, 0, 0, -1, dc, e);
    check_val("rd_latency", 32'(dc), 32'd10);

    run_txn(1'b1, 32'h12345678, 32'hCAFEF00D, 4, 0, 2, -1, dc, e);
    check_val("stall_latency", 32'(dc), 32'd13);

    run_txn(1'b0, 32'hA5A50F0F, 32'h0, 2, 0, 0, -1, dc, e);
    check_val("timeout_cycle", 32'(dc), 32'd24);
    check_val("timeout_err", 32'(e), 32'h1);

    run_txn(1'b0, 32'h0BADF00D, 32'h0, 4, TO - 1, 0, -1, dc, e);
    check_val("coincide_cycle", 32'(dc), 32'd70);
    check_val("coincide_err", 32'(e), 32'h0);

    run_txn(1'b1, 32'h11223344, 32'h55667788, 4, 0, 0, 6, dc, e);
    run_txn(1'b1, 32'h99AABBCC, 32'hDDEEFF00, 4, 0, 0, -1, dc, e);
    check_val("post_reset_latency", 32'(dc), 32'd10);

    for (int t = 0; t < 25; t++) begin
      run_txn(1'($urandom), $urandom, $urandom,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 4,
              -1, 1, -1, dc, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/acom.md
ACOM -- requirements
Module: acom

Interface
REQ-001 Parameter ADDR_SIZE, 4, address bytes sent per command, MSB first.
REQ-002 Parameter DATA_SIZE, 4, data bytes per word, MSB first.
REQ-003 Parameter TIMEOUT, 16'd4095, idle cycles allowed between received read-data bytes before abort.
REQ-004 The block SHALL have one clock, CLK; reset RST_N is asynchronous and active-low.
REQ-005 CLK  in  1  clock, all state changes on rising edge.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 SlvReq  in  1  access request, sampled only in IDLE.
REQ-008 SlvWrite  in  1  1 = write, 0 = read, latched with SlvReq.
REQ-009 SlvAddr  in  32  word address, latched with SlvReq.
REQ-010 SlvWData  in  32  write data, latched with SlvReq.
REQ-011 SlvRData  out  32  read data, valid while SlvOkay=1.
REQ-012 SlvOkay  out  1  one-cycle completion pulse.
REQ-013 SlvErr  out  1  one-cycle read-timeout pulse.
REQ-014 Busy  out  1  high from the cycle after acceptance through the DONE cycle.
REQ-015 Write  out  1  byte strobe to COM transmitter.
REQ-016 DataOut  out  8  byte to COM transmitter, valid while Write=1.
REQ-017 THEmpty  in  1  transmitter can accept a byte this cycle.
REQ-018 Read  out  1  byte-consume strobe to COM receiver.
REQ-019 DataIn  in  8  received byte.
REQ-020 DataReady  in  1  DataIn valid.

Function
REQ-021 States SHALL be IDLE, SEND_CMD, SEND_ADDR, SEND_DATA, RECV_DATA, DONE; one-hot.
REQ-022 IDLE & SlvReq SHALL latch SlvWrite/SlvAddr/SlvWData, clear byte and timeout counters, and go to SEND_CMD next cycle.
REQ-023 SlvReq outside IDLE SHALL be ignored; the requester holds SlvReq until SlvOkay or SlvErr.
REQ-024 The command byte SHALL be {1'b1, latched write, 6'd1}: a single word per command.
REQ-025 In any SEND state, Write SHALL equal THEmpty combinationally; a byte is transferred only in cycles with Write=1.
REQ-026 THEmpty=0 SHALL stall the state and counters with DataOut held.
REQ-027 SEND_CMD SHALL go to SEND_ADDR after 1 transfer.
REQ-028 SEND_ADDR SHALL go to SEND_DATA (write) or RECV_DATA (read) after ADDR_SIZE transfers, address bytes [31:24] first.
REQ-029 SEND_DATA SHALL go to DONE after DATA_SIZE transfers, data bytes [31:24] first.
REQ-030 In RECV_DATA, Read SHALL equal DataReady combinationally.
REQ-031 Each DataReady cycle SHALL shift DataIn into the LSB of a 32-bit receive register and clear the timeout counter.
REQ-032 RECV_DATA SHALL go to DONE after DATA_SIZE received bytes.
REQ-033 The timeout counter SHALL increment on each RECV_DATA cycle without DataReady.
REQ-034 At count TIMEOUT-1 with no DataReady, the block SHALL go to DONE with the error flag set.
REQ-035 DataReady in the same cycle as the timeout SHALL win: the byte is accepted and no error is raised.
REQ-036 DONE SHALL last exactly 1 cycle, then go to IDLE.
REQ-037 In DONE, SlvOkay=1 (no error) or SlvErr=1 (error); never both.
REQ-038 SlvRData SHALL be the receive register for reads and 0 for writes and errors.
REQ-039 Outside RECV_DATA, Read SHALL be 0 and DataIn ignored.
REQ-040 Outside SEND states, Write SHALL be 0 and DataOut 8'h00.

Reset
REQ-041 RST_N low SHALL force IDLE, all counters and registers 0, and every output 0, including mid-transfer; no partial byte resumes after reset.

Verification
REQ-042 Write, THEmpty=1, SlvReq at cycle 0 with addr 0x12345678 and data 0xCAFEF00D -> Write pulses cycles 1-9, bytes C1 12 34 56 78 CA FE F0 0D, SlvOkay cycle 10, Busy 1-10.
REQ-043 Read of addr 0x00000010; DataIn 0xDE 0xAD 0xBE 0xEF one per cycle after last addr byte -> bytes 81 00 00 00 10, Read pulses x4, SlvOkay with SlvRData=0xDEADBEEF.
REQ-044 Write with THEmpty low 3 cycles during the 2nd address byte -> DataOut holds 0x34, byte sequence unchanged, completion delayed 3 cycles.
REQ-045 Read with only 2 data bytes returned, TIMEOUT=16 -> SlvErr one cycle, SlvRData=0, SlvOkay never asserted, back to IDLE.
REQ-046 DataReady coincident with the timeout cycle -> byte accepted, no SlvErr; RST_N pulse during SEND_DATA -> all outputs 0 and next SlvReq starts with command byte.
